// File: rtl/branch_redirect_unit.sv
// Fetch-side PC generator: applies taken-branch/jump redirects, buffers a redirect
// that lands while fetch is stalled, raises a one-cycle IF/ID flush, counts branches.
module branch_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             FetchStall,
  input  logic             ResolveValid,
  input  logic [3:0]       BranchType,
  input  logic             Branch,
  input  logic [31:0]      BranchTarget,
  input  logic [31:0]      JumpTarget,
  output logic [31:0]      PC,
  output logic [31:0]      PCPlus4,
  output logic             Flush,
  output logic [CNT_W-1:0] BranchCount,
  output logic [CNT_W-1:0] TakenCount
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_PEND  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t           r_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_pend_target;
  logic             r_flush;
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_taken_cnt;

  logic             w_is_branch;
  logic             w_is_jump;
  logic             w_taken;
  logic [31:0]      w_raw_target;
  logic [31:0]      w_target;
  logic             w_accept;
  logic             w_redirect;
  logic [31:0]      w_pc_plus4;

  // Codes 0011..1001 form the branch class; 1001 is the unconditional jump.
  assign w_is_branch  = (BranchType >= 4'd3) && (BranchType <= 4'd9);
  assign w_is_jump    = (BranchType == 4'd9);
  assign w_taken      = w_is_jump | Branch;
  assign w_raw_target = w_is_jump ? JumpTarget : BranchTarget;
  assign w_target     = {w_raw_target[31:2], 2'b00};
  assign w_accept     = (r_state == S_RUN) && ResolveValid && w_is_branch;
  assign w_redirect   = w_accept && w_taken;
  assign w_pc_plus4   = r_pc + 32'd4;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state       <= S_RUN;
      r_pc          <= RESET_PC;
      r_pend_target <= 32'd0;
      r_flush       <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_redirect && !FetchStall) begin
            r_pc    <= w_target;
            r_state <= S_FLUSH;
            r_flush <= 1'b1;
          end else if (w_redirect) begin
            r_pend_target <= w_target;
            r_state       <= S_PEND;
            r_flush       <= 1'b0;
          end else begin
            if (!FetchStall) r_pc <= w_pc_plus4;
            r_flush <= 1'b0;
          end
        end
        S_PEND: begin
          if (!FetchStall) begin
            r_pc    <= r_pend_target;
            r_state <= S_FLUSH;
            r_flush <= 1'b1;
          end else begin
            r_flush <= 1'b0;
          end
        end
        S_FLUSH: begin
          // The flush never stretches: a stall here only freezes the PC.
          if (!FetchStall) r_pc <= w_pc_plus4;
          r_state <= S_RUN;
          r_flush <= 1'b0;
        end
        default: begin
          r_state <= S_RUN;
          r_flush <= 1'b0;
        end
      endcase
    end
  end

  // Statistics saturate at all-ones rather than wrapping.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_branch_cnt <= '0;
      r_taken_cnt  <= '0;
    end else begin
      if (w_accept && !(&r_branch_cnt)) r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      if (w_redirect && !(&r_taken_cnt)) r_taken_cnt <= r_taken_cnt + CNT_W'(1);
    end
  end

  assign PC          = r_pc;
  assign PCPlus4     = w_pc_plus4;
  assign Flush       = r_flush;
  assign BranchCount = r_branch_cnt;
  assign TakenCount  = r_taken_cnt;

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed bench for branch_redirect_unit; a narrow-counter copy shares the stimulus
// so counter saturation is reached in a few dozen cycles.
module tb_branch_redirect_unit;

  logic        Clk;
  logic        Reset;
  logic        FetchStall;
  logic        ResolveValid;
  logic [3:0]  BranchType;
  logic        Branch;
  logic [31:0] BranchTarget;
  logic [31:0] JumpTarget;
  logic [31:0] PC, PCPlus4;
  logic        Flush;
  logic [15:0] BranchCount, TakenCount;
  logic [31:0] s_pc, s_pc_plus4;
  logic        s_flush;
  logic [3:0]  s_branch_count, s_taken_count;

  int n_cmp = 0;
  int n_err = 0;

  branch_redirect_unit #(.RESET_PC(32'h0000_0000), .CNT_W(16)) u_dut (
    .Clk(Clk), .Reset(Reset), .FetchStall(FetchStall), .ResolveValid(ResolveValid),
    .BranchType(BranchType), .Branch(Branch), .BranchTarget(BranchTarget),
    .JumpTarget(JumpTarget), .PC(PC), .PCPlus4(PCPlus4), .Flush(Flush),
    .BranchCount(BranchCount), .TakenCount(TakenCount)
  );

  branch_redirect_unit #(.RESET_PC(32'h0000_0000), .CNT_W(4)) u_dut_sat (
    .Clk(Clk), .Reset(Reset), .FetchStall(FetchStall), .ResolveValid(ResolveValid),
    .BranchType(BranchType), .Branch(Branch), .BranchTarget(BranchTarget),
    .JumpTarget(JumpTarget), .PC(s_pc), .PCPlus4(s_pc_plus4), .Flush(s_flush),
    .BranchCount(s_branch_count), .TakenCount(s_taken_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic resolve(input logic [3:0] bt, input logic br, input logic [31:0] btgt,
                         input logic [31:0] jtgt);
    ResolveValid = 1'b1;
    BranchType   = bt;
    Branch       = br;
    BranchTarget = btgt;
    JumpTarget   = jtgt;
  endtask

  task automatic idle();
    ResolveValid = 1'b0;
    BranchType   = 4'd0;
    Branch       = 1'b0;
  endtask

  task automatic chk_state(input string tag, input logic [31:0] pc, input logic fl,
                           input logic [15:0] bc, input logic [15:0] tc);
    chk({tag, ".pc"}, PC, pc);
    chk({tag, ".flush"}, {31'd0, Flush}, {31'd0, fl});
    chk({tag, ".bcnt"}, {16'd0, BranchCount}, {16'd0, bc});
    chk({tag, ".tcnt"}, {16'd0, TakenCount}, {16'd0, tc});
  endtask

  initial begin
    Reset = 1'b0; FetchStall = 1'b0;
    BranchTarget = 32'd0; JumpTarget = 32'd0;
    idle();
    #12;
    chk_state("reset", 32'h0, 1'b0, 16'd0, 16'd0);
    Reset = 1'b1;
    #1;
    chk("release_pc", PC, 32'h0);
    tick(); chk("run1_pc", PC, 32'h4);
    tick(); chk("run2_pc", PC, 32'h8);
    chk("pcplus4", PCPlus4, 32'hC);

    // Taken beq with misaligned target
    resolve(4'b0100, 1'b1, 32'h0000_0103, 32'h0);
    tick(); chk_state("beq", 32'h100, 1'b1, 16'd1, 16'd1);
    idle();
    tick(); chk_state("beq+1", 32'h104, 1'b0, 16'd1, 16'd1);

    // Not-taken bne, then jump with Branch=0
    resolve(4'b0101, 1'b0, 32'h0000_0800, 32'h0);
    tick(); chk_state("bne_nt", 32'h108, 1'b0, 16'd2, 16'd1);
    resolve(4'b1001, 1'b0, 32'h0000_0900, 32'h0000_0040);
    tick(); chk_state("jump", 32'h40, 1'b1, 16'd3, 16'd2);
    idle();
    tick(); chk_state("jump+1", 32'h44, 1'b0, 16'd3, 16'd2);

    // Stalled redirect; second request during PEND must be dropped
    FetchStall = 1'b1;
    resolve(4'b1000, 1'b1, 32'h0000_0200, 32'h0);
    tick(); chk_state("stall1", 32'h44, 1'b0, 16'd4, 16'd3);
    resolve(4'b0100, 1'b1, 32'h0000_0300, 32'h0);
    tick(); chk_state("stall2", 32'h44, 1'b0, 16'd4, 16'd3);
    tick(); chk_state("stall3", 32'h44, 1'b0, 16'd4, 16'd3);
    FetchStall = 1'b0;
    tick(); chk_state("pend_rel", 32'h200, 1'b1, 16'd4, 16'd3);
    idle();
    tick(); chk_state("pend_rel+1", 32'h204, 1'b0, 16'd4, 16'd3);

    // Non-branch codes and invalid resolves do nothing
    resolve(4'b0000, 1'b1, 32'h0000_0A00, 32'h0000_0B00);
    tick(); chk_state("code0000", 32'h208, 1'b0, 16'd4, 16'd3);
    resolve(4'b1010, 1'b1, 32'h0000_0A00, 32'h0000_0B00);
    tick(); chk_state("code1010", 32'h20C, 1'b0, 16'd4, 16'd3);
    resolve(4'b0100, 1'b1, 32'h0000_0A00, 32'h0);
    ResolveValid = 1'b0;
    tick(); chk_state("not_valid", 32'h210, 1'b0, 16'd4, 16'd3);

    // PC wrap, plus a stall during FLUSH that must not stretch Flush
    resolve(4'b1001, 1'b0, 32'h0, 32'hFFFF_FFFF);
    tick(); chk_state("jmp_top", 32'hFFFF_FFFC, 1'b1, 16'd5, 16'd4);
    chk("wrap_plus4", PCPlus4, 32'h0);
    idle();
    FetchStall = 1'b1;
    tick(); chk_state("flush_stall", 32'hFFFF_FFFC, 1'b0, 16'd5, 16'd4);
    FetchStall = 1'b0;
    tick(); chk("wrap_pc", PC, 32'h0);

    // Twelve more taken resolves drive the 4-bit copy to saturation
    for (int i = 0; i < 12; i++) begin
      resolve(4'b0110, 1'b1, 32'h0000_1000, 32'h0);
      tick();
      idle();
      tick();
    end
    chk("bcnt16", {16'd0, BranchCount}, 32'd17);
    chk("tcnt16", {16'd0, TakenCount}, 32'd16);
    chk("sat_bcnt", {28'd0, s_branch_count}, 32'hF);
    chk("sat_tcnt", {28'd0, s_taken_count}, 32'hF);
    resolve(4'b0011, 1'b1, 32'h0000_2000, 32'h0);
    tick(); idle();
    chk("sat_tcnt_hold", {28'd0, s_taken_count}, 32'hF);
    chk("sat_bcnt_hold", {28'd0, s_branch_count}, 32'hF);
    chk("tcnt16_more", {16'd0, TakenCount}, 32'd17);

    // Asynchronous reset while Flush is high
    chk("pre_rst_flush", {31'd0, Flush}, 32'd1);
    #1 Reset = 1'b0;
    #1;
    chk_state("async_rst", 32'h0, 1'b0, 16'd0, 16'd0);
    chk("async_rst_plus4", PCPlus4, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_redirect_unit.md
# branch_redirect_unit

Fetch-side PC generator that consumes the `Branch` result from the branch comparator and the `BranchType` code of the resolving instruction. It holds the program counter, applies taken-branch and jump redirects, and buffers a redirect that arrives while fetch is stalled. It issues a one-cycle IF/ID flush after every redirect and keeps saturating branch statistics. It sits between the branch comparator (resolve stage) and the instruction memory address port.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `CNT_W`, 16, width of the statistics counters.

Ports:
- `Clk`  in  1  single clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `FetchStall`  in  1  freezes the PC (for example, an instruction-memory wait). It does not stall the resolve stage.
- `ResolveValid`  in  1  a real instruction occupies the resolve stage this cycle.
- `BranchType`  in  4  resolving instruction's class: 0011 bgez, 0100 beq, 0101 bne, 0110 bgtz, 0111 blez, 1000 bltz, 1001 jump. All other codes are non-branch.
- `Branch`  in  1  comparator result; meaningful only for codes 0011–1000.
- `BranchTarget`  in  32  conditional-branch target.
- `JumpTarget`  in  32  jump target.
- `PC`  out  32  current fetch address (registered).
- `PCPlus4`  out  32  `PC`+4, combinational, mod 2^32.
- `Flush`  out  1  registered; kills the IF/ID entry.
- `BranchCount`  out  CNT_W  accepted branch-class resolves (codes 0011–1001).
- `TakenCount`  out  CNT_W  accepted resolves that redirected.

## Operation
- Branch-class codes are 0011–1001.
  - Taken is `Branch` for codes 0011–1000. Taken is 1 for code 1001 regardless of `Branch`.
  - Target is `BranchTarget` for codes 0011–1000 and `JumpTarget` for code 1001.
  - Target bits [1:0] are forced to 00.
- A resolve is accepted only in state RUN with `ResolveValid`=1 and a branch-class code.
  - In PEND and FLUSH, `ResolveValid` is ignored: those instructions are wrong-path.
  - Non-branch codes never count or redirect.
- FSM states: RUN, PEND, FLUSH.
  - **RUN, no taken resolve:** if `FetchStall`=0, `PC`<=`PC`+4; otherwise `PC` holds.
  - **RUN, taken resolve, `FetchStall`=0:** `PC`<=target. Go to FLUSH.
  - **RUN, taken resolve, `FetchStall`=1:** PendTarget<=target and `PC` holds. Go to PEND.
  - **PEND:** `PC` holds while `FetchStall`=1. On the first edge with `FetchStall`=0, `PC`<=PendTarget. Go to FLUSH.
  - **FLUSH:** `Flush`=1 for exactly this one cycle. `PC` advances by +4 if `FetchStall`=0, otherwise holds. Always return to RUN on the next edge.
- `Flush` is 1 if and only if the state is FLUSH.
- Counters:
  - `BranchCount` increments by 1 per accepted resolve.
  - `TakenCount` increments by 1 per accepted taken resolve. Counting happens at acceptance, including the RUN→PEND edge.
  - Both counters saturate at all-ones and never wrap.
- PC arithmetic is 32-bit unsigned: 32'hFFFF_FFFC + 4 = 32'h0000_0000.

## Timing
- **Reset (`Reset`=0, asynchronous):**
  - `PC`=`RESET_PC`, state=RUN, `Flush`=0, PendTarget=0, both counters 0.
  - Outputs take these values immediately, without waiting for a clock edge.
  - Reset asserted mid-PEND or mid-FLUSH discards the pending redirect.
- Release is taken synchronously: the first update occurs on the first rising edge after `Reset` goes high.
- Redirect latency when not stalled: a taken resolve in cycle N gives `PC`=target and `Flush`=1 in cycle N+1, and `PC`=target+4 in cycle N+2.
- Stalled redirect: `PC`=PendTarget and `Flush`=1 in the cycle after the first edge sampling `FetchStall`=0.
- Simultaneous events:
  - Reset dominates everything.
  - A taken resolve beats +4.
  - `FetchStall` in FLUSH holds `PC` but does not extend `Flush`.
  - Back-to-back taken resolves in consecutive cycles: the second is ignored, because it arrives in FLUSH or PEND.
- No combinational path from any input to `PC` or `Flush`. `PCPlus4` depends only on `PC`.

## Test plan
- **Reset and run:** `RESET_PC`=0; release reset and idle 4 cycles → `PC` = 0, 4, 8, 12; `Flush`=0; counters 0.
- **Taken beq:** at `PC`=8, `BranchType`=0100, `Branch`=1, `BranchTarget`=32'h0000_0103 → next cycle `PC`=32'h100 and `Flush`=1; then `PC`=32'h104 and `Flush`=0; `BranchCount`=1, `TakenCount`=1.
- **Not-taken and jump:**
  - bne with `Branch`=0 → `PC`+4 and no flush.
  - Then `BranchType`=1001 with `Branch`=0 and `JumpTarget`=32'h40 → `PC`=32'h40 with a flush.
  - Result: `BranchCount`=2, `TakenCount`=1.
- **Stalled redirect:**
  - Hold `FetchStall`=1 for 3 cycles. Present a taken bltz to 32'h200 in the first cycle, then present a taken beq to 32'h300 during PEND.
  - Required: `PC` frozen during the stall; after release, `PC`=32'h200 with `Flush`=1; the 32'h300 request is ignored; `TakenCount`=1.
- **Ignored codes:** `ResolveValid`=1 with `BranchType`=0000 and with 1010, `Branch`=1 → no redirect, no count.
- **Boundaries:**
  - `PC`=32'hFFFF_FFFC, advance → `PC`=0.
  - Force `TakenCount` to 16'hFFFF via 65535 taken resolves, then one more taken resolve → `TakenCount` stays 16'hFFFF.
  - Assert `Reset` during FLUSH → `Flush`=0 and `PC`=`RESET_PC` immediately.
